// File: rtl/swdebounce.sv
// -----------------------------------------------------------------------------
// swdebounce
//
// Input conditioner for board switches and pushbuttons. Each of N_SW raw
// switch lines is (optionally) synchronized, then debounced by a per-channel
// two-state FSM with a stability counter. The result is a clean level plus
// single-cycle rise/fall pulses.
//
// Compile-time option:
//   SWDEBOUNCE_SYNC_EN  when defined, a 2-FF synchronizer sits ahead of each
//                       channel's FSM (+2 cycles latency). Required whenever
//                       i_sw comes from real, asynchronous switches. When
//                       undefined, i_sw feeds the FSM directly.
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset    synchronous, active-low reset
//   i_sw       [N_SW] raw switch levels (asynchronous to i_clock)
//   o_sw       [N_SW] debounced level per channel
//   o_sw_rise  [N_SW] one-cycle pulse on an accepted 0->1 transition
//   o_sw_fall  [N_SW] one-cycle pulse on an accepted 1->0 transition
//   o_busy     high while any channel is in PENDING
//
// Parameters:
//   N_SW             number of channels
//   NB_COUNTER       width of each stability counter
//   DEBOUNCE_CYCLES  consecutive samples a new level must persist
//                    (2 .. 2**NB_COUNTER-1)
// -----------------------------------------------------------------------------
module swdebounce #(
  parameter int N_SW            = 4,
  parameter int NB_COUNTER      = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_sw,
  output logic [N_SW-1:0] o_sw_rise,
  output logic [N_SW-1:0] o_sw_fall,
  output logic            o_busy
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Count value on which a pending level is accepted; it always fits in
  // NB_COUNTER bits for a legal DEBOUNCE_CYCLES, so the counter never wraps.
  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);

  logic [N_SW-1:0]       samp;
  state_t                state [N_SW];
  logic [NB_COUNTER-1:0] cnt   [N_SW];
  logic [N_SW-1:0]       pend_nxt;

`ifdef SWDEBOUNCE_SYNC_EN
  logic [N_SW-1:0] sync_p0;
  logic [N_SW-1:0] sync_p1;

  // Stage p0 -> p1: two-flop synchronizer per channel
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_sw;
      sync_p1 <= sync_p0;
    end
  end

  assign samp = sync_p1;
`else
  assign samp = i_sw;
`endif

  // A channel is PENDING after this edge when its sample disagrees with the
  // accepted level, unless this very edge is the one that accepts it.
  always_comb begin
    pend_nxt = '0;
    for (int n = 0; n < N_SW; n++) begin
      pend_nxt[n] = (samp[n] != o_sw[n]) &&
                    !((state[n] == ST_PENDING) && (cnt[n] == CNT_LAST));
    end
  end

  // Debounce FSM stage: state, counters and all outputs registered together
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int n = 0; n < N_SW; n++) begin
        state[n] <= ST_STABLE;
        cnt[n]   <= '0;
      end
      o_sw      <= '0;
      o_sw_rise <= '0;
      o_sw_fall <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_sw_rise <= '0;
      o_sw_fall <= '0;
      o_busy    <= |pend_nxt;
      for (int n = 0; n < N_SW; n++) begin
        if (state[n] == ST_STABLE) begin
          if (samp[n] != o_sw[n]) begin
            cnt[n]   <= CNT_ONE;
            state[n] <= ST_PENDING;
          end
        end else begin
          if (samp[n] == o_sw[n]) begin
            // Glitch: the sample fell back before it was accepted
            cnt[n]   <= '0;
            state[n] <= ST_STABLE;
          end else if (cnt[n] == CNT_LAST) begin
            o_sw[n]      <= samp[n];
            o_sw_rise[n] <= samp[n];
            o_sw_fall[n] <= ~samp[n];
            cnt[n]       <= '0;
            state[n]     <= ST_STABLE;
          end else begin
            cnt[n] <= cnt[n] + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_swdebounce.sv
// -----------------------------------------------------------------------------
// tb_swdebounce
//
// Self-checking bench for swdebounce with N_SW=4, DEBOUNCE_CYCLES=4.
// A table of per-cycle input/expected-output records covers clean rise,
// glitch rejection, bounce-then-settle, fall and simultaneous transitions.
// Expected values are written for a direct (unsynchronized) sample path; when
// SWDEBOUNCE_SYNC_EN is defined the comparison is lagged by the two
// synchronizer cycles. Hand-written sequences cover reset during PENDING and
// reset on the same edge as an acceptance.
// -----------------------------------------------------------------------------
module tb_swdebounce;

  localparam int N_SW = 4;
  localparam int NB   = 20;
  localparam int DC   = 4;
`ifdef SWDEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic            i_clock;
  logic            i_reset;
  logic [N_SW-1:0] i_sw;
  logic [N_SW-1:0] o_sw;
  logic [N_SW-1:0] o_sw_rise;
  logic [N_SW-1:0] o_sw_fall;
  logic            o_busy;

  int checks   = 0;
  int failures = 0;

  swdebounce #(
    .N_SW            (N_SW),
    .NB_COUNTER      (NB),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_sw      (i_sw),
    .o_sw      (o_sw),
    .o_sw_rise (o_sw_rise),
    .o_sw_fall (o_sw_fall),
    .o_busy    (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] o;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] sw, input logic [3:0] o,
                     input logic [3:0] rise, input logic [3:0] fall,
                     input logic busy);
    vec_t v;
    v.sw   = sw;
    v.o    = o;
    v.rise = rise;
    v.fall = fall;
    v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    int nv;
    int j;
    int rise_cnt;
    logic [3:0] e_rise;
    logic [3:0] e_o;
    logic       e_busy;

    // Expected outputs after the edge that samples each row (direct path)
    //   sw       o_sw     rise     fall     busy
    // clean rise on channel 0
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    // glitch on channel 1 lasting 3 samples
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    // bounce on channel 2: 1,0,1,0,1 then hold 1
    add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(4'b0101, 4'b0101, 4'b0100, 4'b0000, 1'b0);
    add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    // settle to 0011: channel 1 rises, channel 2 falls
    add(4'b0011, 4'b0101, 4'b0000, 4'b0000, 1'b1);
    add(4'b0011, 4'b0101, 4'b0000, 4'b0000, 1'b1);
    add(4'b0011, 4'b0101, 4'b0000, 4'b0000, 1'b1);
    add(4'b0011, 4'b0011, 4'b0010, 4'b0100, 1'b0);
    add(4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    // simultaneous 0011 -> 1100
    add(4'b1100, 4'b0011, 4'b0000, 4'b0000, 1'b1);
    add(4'b1100, 4'b0011, 4'b0000, 4'b0000, 1'b1);
    add(4'b1100, 4'b0011, 4'b0000, 4'b0000, 1'b1);
    add(4'b1100, 4'b1100, 4'b1100, 4'b0011, 1'b0);
    add(4'b1100, 4'b1100, 4'b0000, 4'b0000, 1'b0);

    // Reset state
    i_reset = 1'b0;
    i_sw    = 4'b0000;
    repeat (3) tick();
    check("reset o_sw",      o_sw,      4'b0000);
    check("reset o_sw_rise", o_sw_rise, 4'b0000);
    check("reset o_sw_fall", o_sw_fall, 4'b0000);
    check("reset o_busy",    o_busy,    1'b0);
    i_reset = 1'b1;
    repeat (3) tick();
    check("idle o_busy", o_busy, 1'b0);

    // Table-driven vectors, comparison lagged by the synchronizer depth
    nv = tbl.size();
    for (int i = 0; i < nv + SYNC_LAT; i++) begin
      i_sw = tbl[(i < nv) ? i : nv - 1].sw;
      tick();
      if (i >= SYNC_LAT) begin
        j = i - SYNC_LAT;
        check($sformatf("row%0d o_sw", j),      o_sw,      tbl[j].o);
        check($sformatf("row%0d o_sw_rise", j), o_sw_rise, tbl[j].rise);
        check($sformatf("row%0d o_sw_fall", j), o_sw_fall, tbl[j].fall);
        check($sformatf("row%0d o_busy", j),    o_busy,    tbl[j].busy);
      end
    end

    // Reset while channel 0 is PENDING with cnt=2, switch held high after
    i_sw = 4'b1101;
    repeat (SYNC_LAT + 2) tick();
    check("midpend o_busy", o_busy, 1'b1);
    check("midpend o_sw",   o_sw,   4'b1100);
    i_reset = 1'b0;
    i_sw    = 4'b0001;
    tick();
    check("rstpend o_sw",      o_sw,      4'b0000);
    check("rstpend o_sw_rise", o_sw_rise, 4'b0000);
    check("rstpend o_sw_fall", o_sw_fall, 4'b0000);
    check("rstpend o_busy",    o_busy,    1'b0);
    i_reset  = 1'b1;
    rise_cnt = 0;
    for (int k = 1; k <= SYNC_LAT + DC + 1; k++) begin
      tick();
      e_rise = (k == SYNC_LAT + DC) ? 4'b0001 : 4'b0000;
      e_o    = (k >= SYNC_LAT + DC) ? 4'b0001 : 4'b0000;
      e_busy = (k > SYNC_LAT) && (k < SYNC_LAT + DC);
      if (o_sw_rise[0]) rise_cnt++;
      check($sformatf("relrise k%0d o_sw_rise", k), o_sw_rise, e_rise);
      check($sformatf("relrise k%0d o_sw", k),      o_sw,      e_o);
      check($sformatf("relrise k%0d o_sw_fall", k), o_sw_fall, 4'b0000);
      check($sformatf("relrise k%0d o_busy", k),    o_busy,    e_busy);
    end
    check("relrise pulse count", rise_cnt, 1);

    // Reset on the same edge that would accept a fall on channel 0
    i_sw = 4'b0000;
    repeat (SYNC_LAT + 3) tick();
    check("preaccept o_busy", o_busy, 1'b1);
    check("preaccept o_sw",   o_sw,   4'b0001);
    i_reset = 1'b0;
    tick();
    check("rstaccept o_sw_fall", o_sw_fall, 4'b0000);
    check("rstaccept o_sw",      o_sw,      4'b0000);
    check("rstaccept o_busy",    o_busy,    1'b0);
    i_reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("postrst k%0d o_sw", k),      o_sw,      4'b0000);
      check($sformatf("postrst k%0d o_sw_rise", k), o_sw_rise, 4'b0000);
      check($sformatf("postrst k%0d o_sw_fall", k), o_sw_fall, 4'b0000);
      check($sformatf("postrst k%0d o_busy", k),    o_busy,    1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swdebounce.md
# swdebounce

Input-side conditioner for the board switches and pushbuttons that feed the LED shifter top level. Each of N_SW raw, asynchronous switch lines is synchronized, debounced with a per-channel stability counter, and presented as a clean level plus single-cycle rise/fall pulses. Downstream logic (speed select, direction select, colour select) consumes these instead of raw `i_sw` bits.

## Interface
- `N_SW`, 4: number of independent switch channels.
- `NB_COUNTER`, 20: width of each channel's stability counter.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new level must persist before it is accepted. Legal range is 2 to 2^NB_COUNTER-1.
- `i_clock`  input  1  system clock; all logic on rising edge.
- `i_reset`  input  1  synchronous, active-low reset.
- `i_sw`  input  N_SW  raw switch levels, asynchronous to `i_clock`.
- `o_sw`  output  N_SW  debounced level per channel.
- `o_sw_rise`  output  N_SW  one-cycle pulse when `o_sw[n]` goes 0→1.
- `o_sw_fall`  output  N_SW  one-cycle pulse when `o_sw[n]` goes 1→0.
- `o_busy`  output  1  OR of all channels in PENDING.

## Operation
- Each channel is independent. There is no interaction between channels except through `o_busy`.
- Sample `s[n]`:
  - With the synchronizer compiled in, `s[n]` is the output of a 2-FF synchronizer on `i_sw[n]`.
  - Otherwise `s[n]` is `i_sw[n]` directly.
- Per-channel FSM with two states, STABLE and PENDING, and a counter `cnt[n]`.
- In STABLE (`cnt` = 0):
  - If `s` == `o_sw`, stay in STABLE.
  - If `s` != `o_sw`, set `cnt` to 1 and go to PENDING.
- In PENDING:
  - If `s` == `o_sw` (a glitch), clear `cnt` to 0 and return to STABLE. No output change.
  - If `s` != `o_sw` and `cnt` < DEBOUNCE_CYCLES-1, increment `cnt`.
  - If `s` != `o_sw` and `cnt` == DEBOUNCE_CYCLES-1:
    - `o_sw` <= `s`.
    - Pulse `o_sw_rise` if `s`=1, or `o_sw_fall` if `s`=0.
    - Clear `cnt` and go to STABLE.
- `cnt` never wraps. The terminal compare fires before overflow for any legal DEBOUNCE_CYCLES.
- `o_sw_rise[n]` and `o_sw_fall[n]` are never both high. Each is high for exactly one cycle per accepted transition.
- Reset (`i_reset`=0 at a rising edge):
  - Sync flops, `cnt`, state, `o_sw`, `o_sw_rise`, `o_sw_fall` and `o_busy` all go to 0, and the FSM goes to STABLE.
  - Reset overrides any pending acceptance on the same edge.
  - Reset mid-PENDING discards the partial count.
- A switch held high through reset is accepted as a normal 0→1 transition after release. It produces one `o_sw_rise` pulse.

## Timing
- All outputs are registered. No combinational path from `i_sw` to any output.
- Acceptance timing, without the synchronizer:
  - `i_sw[n]` changes and holds before edge k.
  - `o_sw[n]` and the edge pulse update at edge k+DEBOUNCE_CYCLES-1.
  - The pulse is deasserted at edge k+DEBOUNCE_CYCLES.
- With the synchronizer, the same timing applies shifted by +2 edges.
- Glitch rejection: a change lasting fewer than DEBOUNCE_CYCLES consecutive samples produces no output change and no pulse.
- `o_busy` is registered alongside state. It is high in every cycle in which any channel is in PENDING.
- Simultaneous transitions on several channels are accepted independently. Each gets its own pulse, possibly on the same cycle.

## Configuration
- `SWDEBOUNCE_SYNC_EN`:
  - When defined, each channel has a 2-FF synchronizer ahead of the FSM, adding 2 cycles of latency. This is mandatory for synthesis against real switches.
  - When undefined, `i_sw` feeds the FSM directly. This is intended only for cycle-exact simulation with clock-aligned stimulus.

## Test plan
All scenarios use N_SW=4 and DEBOUNCE_CYCLES=4, with `SWDEBOUNCE_SYNC_EN` defined.
- **Clean rise:** set `i_sw`=4'b0001 before edge 0 and hold.
  - Required: `o_sw`=4'b0001 and `o_sw_rise`=4'b0001 from edge 5.
  - Required: `o_sw_rise` back to 0 at edge 6, and `o_busy` high edges 2–4.
- **Glitch:** with `o_sw`=0, drive `i_sw[1]`=1 for 3 cycles, then 0.
  - Required: `o_sw`, `o_sw_rise` and `o_sw_fall` stay 0 throughout.
  - Required: `o_busy` pulses high then returns to 0.
- **Bounce then settle:** toggle `i_sw[2]` 1,0,1,0,1 every cycle, then hold 1.
  - Required: exactly one `o_sw_rise[2]` pulse, occurring 4 samples after the final settle.
  - Required: no `o_sw_fall[2]` pulse.
- **Simultaneous channels:** change `i_sw` from 4'b0011 to 4'b1100 in one cycle, from a settled 4'b0011.
  - Required: on one cycle, `o_sw_rise`=4'b1100 and `o_sw_fall`=4'b0011.
  - Required: `o_sw`=4'b1100 afterwards.
- **Reset mid-pending:** assert `i_reset`=0 for one edge while channel 0 is in PENDING with `cnt`=2.
  - Required: all outputs 0 at the following edge.
  - Required: if `i_sw[0]`=1 is still held, the rise is accepted 4 samples after the synchronizer refills (at the 6th edge after reset release), with one `o_sw_rise[0]` pulse.
